// File: rtl/warp_fetch_scheduler.sv
// Warp fetch scheduler: per-warp PCs, valid bits and IBuffer credits,
// dual round-robin grant selection feeding the two I-Cache ports.
module warp_fetch_scheduler #(
  parameter int          CREDITS  = 4,
  parameter int          CREDIT_W = 3,
  parameter logic [31:0] PC_RST   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Fetch_En,
  input  logic        Init_Valid,
  input  logic [2:0]  Init_Warp,
  input  logic [31:0] Init_PC,
  input  logic        Exit_Valid,
  input  logic [2:0]  Exit_Warp,
  input  logic        Redirect_Valid,
  input  logic [2:0]  Redirect_Warp,
  input  logic [31:0] Redirect_PC,
  input  logic [7:0]  Credit_Return,
  output logic [31:0] PC0_PC_IF,
  output logic [31:0] PC1_PC_IF,
  output logic [31:0] PC2_PC_IF,
  output logic [31:0] PC3_PC_IF,
  output logic [31:0] PC4_PC_IF,
  output logic [31:0] PC5_PC_IF,
  output logic [31:0] PC6_PC_IF,
  output logic [31:0] PC7_PC_IF,
  output logic [7:0]  GRT_raw_1_RR_IF,
  output logic [7:0]  GRT_raw_2_RR_IF,
  output logic [7:0]  PC_Valid
);

  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDITS);

  logic [31:0]         pc_q     [8];
  logic [CREDIT_W-1:0] credit_q [8];
  logic [7:0]          valid_q;
  logic [2:0]          rr_ptr;
  logic [2:0]          rr_next;

  logic [7:0] elig;
  logic [7:0] rot;
  logic [7:0] g1;
  logic [7:0] g2;
  logic [7:0] grant;
  logic       found1;
  logic       found2;
  logic [2:0] k1;
  logic [2:0] k2;
  logic [2:0] i1;
  logic [2:0] i2;

  // Eligibility uses only registered state and Fetch_En.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 8; i++) begin
      elig[i] = Fetch_En & valid_q[i] & (credit_q[i] != '0);
    end
  end

  // Scan rotated so position 0 is rr_ptr; second pick stops before wrap.
  always_comb begin
    rot    = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    k1     = '0;
    k2     = '0;
    for (int k = 0; k < 8; k++) begin
      rot[k] = elig[rr_ptr + 3'(k)];
    end
    for (int k = 0; k < 8; k++) begin
      if (rot[k]) begin
        if (!found1) begin
          found1 = 1'b1;
          k1     = 3'(k);
        end else if (!found2) begin
          found2 = 1'b1;
          k2     = 3'(k);
        end
      end
    end
    i1 = rr_ptr + k1;
    i2 = rr_ptr + k2;
    g1 = found1 ? (8'd1 << i1) : 8'd0;
    g2 = found2 ? (8'd1 << i2) : 8'd0;
    if (found2) begin
      rr_next = i2 + 3'd1;
    end else if (found1) begin
      rr_next = i1 + 3'd1;
    end else begin
      rr_next = rr_ptr;
    end
  end

  assign grant = g1 | g2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      valid_q <= '0;
      for (int i = 0; i < 8; i++) begin
        pc_q[i]     <= PC_RST;
        credit_q[i] <= CMAX;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int i = 0; i < 8; i++) begin
        if (Init_Valid && Init_Warp == 3'(i)) begin
          pc_q[i] <= Init_PC;
        end else if (Redirect_Valid && Redirect_Warp == 3'(i) && valid_q[i]) begin
          pc_q[i] <= Redirect_PC;
        end else if (grant[i]) begin
          pc_q[i] <= pc_q[i] + 32'd4;
        end

        if (Init_Valid && Init_Warp == 3'(i)) begin
          valid_q[i] <= 1'b1;
        end else if (Exit_Valid && Exit_Warp == 3'(i)) begin
          valid_q[i] <= 1'b0;
        end

        if (Init_Valid && Init_Warp == 3'(i)) begin
          credit_q[i] <= CMAX;
        end else if (grant[i] && !Credit_Return[i]) begin
          credit_q[i] <= credit_q[i] - 1'b1;
        end else if (!grant[i] && Credit_Return[i] && credit_q[i] != CMAX) begin
          credit_q[i] <= credit_q[i] + 1'b1;
        end
      end
    end
  end

  assign PC0_PC_IF       = pc_q[0];
  assign PC1_PC_IF       = pc_q[1];
  assign PC2_PC_IF       = pc_q[2];
  assign PC3_PC_IF       = pc_q[3];
  assign PC4_PC_IF       = pc_q[4];
  assign PC5_PC_IF       = pc_q[5];
  assign PC6_PC_IF       = pc_q[6];
  assign PC7_PC_IF       = pc_q[7];
  assign GRT_raw_1_RR_IF = g1;
  assign GRT_raw_2_RR_IF = g2;
  assign PC_Valid        = valid_q;

endmodule
